key_event_decoder: RTL and testbench

Converts the clean, active-high "button pressed" level produced by the board debouncer into single-cycle key events: press, release, long-press, and auto-repeat while held. It sits directly downstream of the debouncer, one instance per push-button. It feeds the DE10-Lite control logic, which steps ADC channel and display settings only on events, never on raw levels.

---
 rtl/key_event_decoder_if.sv | 27 ++
 rtl/key_event_decoder.sv | 107 ++++++++++
 tb/tb_key_event_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/key_event_decoder_if.sv
// Key event bundle: debounced key level in, single-cycle events and held level out.
interface key_event_decoder_if;
    logic pressed;
    logic press_evt;
    logic release_evt;
    logic long_evt;
    logic repeat_evt;
    logic held;

    modport master (
        output pressed,
        input  press_evt,
        input  release_evt,
        input  long_evt,
        input  repeat_evt,
        input  held
    );

    modport slave (
        input  pressed,
        output press_evt,
        output release_evt,
        output long_evt,
        output repeat_evt,
        output held
    );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/long-press/auto-repeat pulses.
// All outputs are registered; release always wins over a threshold event.
module key_event_decoder #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned LONG_CYCLES   = 5_000_000,
    parameter int unsigned REPEAT_PERIOD = 1_000_000,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    key_event_decoder_if.slave   kif
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             RPT_ON      = (REPEAT_EN != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt_q, press_evt_d;
    logic             release_evt_q, release_evt_d;
    logic             long_evt_q, long_evt_d;
    logic             repeat_evt_q, repeat_evt_d;
    logic             held_q, held_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        long_evt_d    = 1'b0;
        repeat_evt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (kif.pressed) begin
                    press_evt_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = PRESS;
                end
            end
            PRESS: begin
                if (!kif.pressed) begin
                    release_evt_d = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_evt_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // With repeat disabled the counter freezes so it can never wrap.
                if (!kif.pressed) begin
                    release_evt_d = 1'b1;
                    state_d       = IDLE;
                end else if (RPT_ON && (cnt_q == REPEAT_LAST)) begin
                    repeat_evt_d = 1'b1;
                    cnt_d        = '0;
                end else if (RPT_ON) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
            long_evt_q    <= 1'b0;
            repeat_evt_q  <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
            long_evt_q    <= long_evt_d;
            repeat_evt_q  <= repeat_evt_d;
            held_q        <= held_d;
        end
    end

    assign kif.press_evt   = press_evt_q;
    assign kif.release_evt = release_evt_q;
    assign kif.long_evt    = long_evt_q;
    assign kif.repeat_evt  = repeat_evt_q;
    assign kif.held        = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Drives two decoders (repeat on / repeat off) from one key stream and compares
// every cycle against a hold-duration model of the event rules.
module tb_key_event_decoder;

    localparam int unsigned LONG = 8;
    localparam int unsigned RP   = 4;

    logic clk;
    logic reset;

    key_event_decoder_if kif_rep ();
    key_event_decoder_if kif_norep ();

    key_event_decoder #(
        .CNT_W(8), .LONG_CYCLES(LONG), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
    ) dut_rep (
        .clk(clk), .reset(reset), .kif(kif_rep.slave)
    );

    key_event_decoder #(
        .CNT_W(8), .LONG_CYCLES(LONG), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
    ) dut_norep (
        .clk(clk), .reset(reset), .kif(kif_norep.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cycle    = 0;

    // Model: per instance, whether a key press is active and how many cycles since press_evt.
    bit active [2];
    int k      [2];

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got{prs,rel,lng,rpt,held}=%b exp=%b", tag, cycle, got, exp);
        end
    endtask

    // Returns expected {press,release,long,repeat,held} after one edge.
    function automatic logic [4:0] model_step(input int i, input bit r, input bit p, input bit rep_en);
        logic prs, rel, lng, rpt;
        prs = 0; rel = 0; lng = 0; rpt = 0;
        if (r) begin
            active[i] = 0;
            k[i]      = 0;
        end else if (!active[i]) begin
            if (p) begin
                prs       = 1;
                active[i] = 1;
                k[i]      = 0;
            end
        end else if (!p) begin
            rel       = 1;
            active[i] = 0;
        end else begin
            k[i]++;
            if (k[i] == LONG)
                lng = 1;
            else if (rep_en && k[i] > LONG && ((k[i] - LONG) % RP) == 0)
                rpt = 1;
        end
        return {prs, rel, lng, rpt, r ? 1'b0 : logic'(active[i])};
    endfunction

    task automatic step(input bit r, input bit p);
        logic [4:0] e1, e0;
        @(negedge clk);
        reset           = r;
        kif_rep.pressed   = p;
        kif_norep.pressed = p;
        @(posedge clk);
        cycle++;
        e1 = model_step(1, r, p, 1'b1);
        e0 = model_step(0, r, p, 1'b0);
        #1;
        check("rep_en1", {kif_rep.press_evt, kif_rep.release_evt, kif_rep.long_evt,
                          kif_rep.repeat_evt, kif_rep.held}, e1);
        check("rep_en0", {kif_norep.press_evt, kif_norep.release_evt, kif_norep.long_evt,
                          kif_norep.repeat_evt, kif_norep.held}, e0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        reset             = 1'b1;
        kif_rep.pressed   = 1'b1;
        kif_norep.pressed = 1'b1;
        active[0] = 0; active[1] = 0; k[0] = 0; k[1] = 0;

        // Reset held with key down, then the key reads as a fresh press.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold(3);
        idle(3);

        hold(5);  idle(3);   // short press
        hold(20); idle(3);   // long hold with repeats
        hold(8);  idle(3);   // release on the long threshold edge
        hold(12); idle(3);   // release on the first repeat threshold edge
        hold(1);  idle(1);   // one-cycle press, minimum re-press gap
        hold(1);  idle(2);

        // Reset while in HOLD with the key still down.
        hold(11);
        step(1'b1, 1'b1);
        hold(12); idle(3);

        hold(30); idle(3);   // long run exercises frozen counter with repeat off

        for (int seg = 0; seg < 120; seg++) begin
            int unsigned hl, il;
            hl = $urandom_range(1, 40);
            il = $urandom_range(1, 5);
            for (int unsigned i = 0; i < hl; i++)
                step(($urandom_range(0, 63) == 0), 1'b1);
            for (int unsigned i = 0; i < il; i++)
                step(($urandom_range(0, 63) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
